// File: rtl/ethernet_rx.sv
// RMII receive path: deserialises dibits, filters on destination MAC and
// ethertype, checks the CRC-32 FCS and turns a 5-byte payload into one
// single-cycle bus request.
module ethernet_rx #(
    parameter logic [47:0] FPGA_MAC  = 48'h12_34_56_78_9A_BC,
    parameter logic [15:0] ETHERTYPE = 16'h0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic [15:0] addr_o,
    output logic [15:0] wdata_o,
    output logic        rw_o,
    output logic        valid_o
);

    typedef enum logic [2:0] {
        WAIT_QUIET, IDLE, PREAMBLE, DEST, SRC, ETYPE, PAYLOAD, DROP
    } state_t;

    localparam logic [31:0] CRC_POLY_R  = 32'hEDB88320;   // 0x04C11DB7 bit-reversed
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MAX_LEN     = 11'd1518;
    localparam logic [10:0] MIN_LEN     = 11'd64;

    state_t      r_state, w_next;
    logic [5:0]  r_byte;        // upper six bits of the byte being assembled
    logic [1:0]  r_dib;
    logic [10:0] r_bcnt;        // completed bytes since the SFD
    logic [39:0] r_field;       // last five completed bytes, for field compares
    logic [31:0] r_crc;
    logic        r_sh_rw;
    logic [15:0] r_sh_addr, r_sh_wdata;
    logic        r_rw, r_valid;
    logic [15:0] r_addr, r_wdata;

    logic        w_in_frame, w_shift, w_byte_done, w_too_long, w_accept;
    logic [7:0]  w_new_byte;

    // Reflected CRC-32 advanced by one dibit, bit 0 first on the wire
    function automatic logic [31:0] f_crc_dibit(input logic [31:0] c_in, input logic [1:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int i = 0; i < 2; i++) begin
            fb = c[0] ^ d[i];
            c  = {1'b0, c[31:1]} ^ (fb ? CRC_POLY_R : 32'h0);
        end
        return c;
    endfunction

    assign w_in_frame  = (r_state == DEST) || (r_state == SRC) ||
                         (r_state == ETYPE) || (r_state == PAYLOAD);
    assign w_shift     = w_in_frame && crsdv;
    assign w_new_byte  = {rxd, r_byte};
    assign w_byte_done = w_shift && (r_dib == 2'd3);
    assign w_too_long  = r_bcnt > MAX_LEN;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WAIT_QUIET;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            WAIT_QUIET: if (!crsdv) w_next = IDLE;
            IDLE:       if (crsdv) w_next = PREAMBLE;
            PREAMBLE: begin
                if (!crsdv)              w_next = IDLE;
                else if (rxd == 2'b11)   w_next = DEST;
                else if (rxd == 2'b10)   w_next = DROP;
            end
            DEST: begin
                if (!crsdv) w_next = IDLE;
                else if (w_byte_done && r_bcnt == 11'd5)
                    w_next = ({r_field, w_new_byte} == FPGA_MAC) ? SRC : DROP;
            end
            SRC: begin
                if (!crsdv) w_next = IDLE;
                else if (w_byte_done && r_bcnt == 11'd11) w_next = ETYPE;
            end
            ETYPE: begin
                if (!crsdv) w_next = IDLE;
                else if (w_byte_done && r_bcnt == 11'd13)
                    w_next = ({r_field[7:0], w_new_byte} == ETHERTYPE) ? PAYLOAD : DROP;
            end
            PAYLOAD: begin
                if (!crsdv)          w_next = IDLE;
                else if (w_too_long) w_next = DROP;
            end
            DROP:       if (!crsdv) w_next = IDLE;
            default:    w_next = WAIT_QUIET;
        endcase
    end

    // Output decode: end-of-frame acceptance test
    always_comb begin
        w_accept = 1'b0;
        if (r_state == PAYLOAD && !crsdv)
            w_accept = (r_bcnt >= MIN_LEN) && !w_too_long &&
                       (r_dib == 2'd0) && (r_crc == CRC_RESIDUE);
    end

    // Dibit shifter, byte/dibit counters and running CRC; cleared outside a frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byte  <= '0;
            r_dib   <= '0;
            r_bcnt  <= '0;
            r_field <= '0;
            r_crc   <= 32'hFFFF_FFFF;
        end else if (!w_in_frame) begin
            r_dib   <= '0;
            r_bcnt  <= '0;
            r_crc   <= 32'hFFFF_FFFF;
        end else if (crsdv) begin
            r_byte <= w_new_byte[7:2];
            r_dib  <= r_dib + 2'd1;
            r_crc  <= f_crc_dibit(r_crc, rxd);
            if (r_dib == 2'd3) begin
                r_field <= {r_field[31:0], w_new_byte};
                if (r_bcnt != 11'h7FF) r_bcnt <= r_bcnt + 11'd1;
            end
        end
    end

    // Shadow capture of payload bytes 0..4 (frame offsets 14..18)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_rw    <= 1'b0;
            r_sh_addr  <= '0;
            r_sh_wdata <= '0;
        end else if (w_byte_done && r_state == PAYLOAD) begin
            case (r_bcnt)
                11'd14:  r_sh_rw           <= w_new_byte[0];
                11'd15:  r_sh_addr[15:8]   <= w_new_byte;
                11'd16:  r_sh_addr[7:0]    <= w_new_byte;
                11'd17:  r_sh_wdata[15:8]  <= w_new_byte;
                11'd18:  r_sh_wdata[7:0]   <= w_new_byte;
                default: ;
            endcase
        end
    end

    // Request outputs: published only on accept, held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rw    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_rw    <= r_sh_rw;
                r_addr  <= r_sh_addr;
                r_wdata <= r_sh_wdata;
            end
        end
    end

    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign rw_o    = r_rw;
    assign valid_o = r_valid;

endmodule
